// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the L2 request path: request packet, core count and
// the requester id width that the response router also uses.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif
`ifndef L2_REQUESTER_ID_WIDTH
`define L2_REQUESTER_ID_WIDTH $clog2(`NUM_CORES)
`endif

package l2_request_arbiter_pkg;
  localparam int NUM_CORES             = `NUM_CORES;
  localparam int L2_REQUESTER_ID_WIDTH = `L2_REQUESTER_ID_WIDTH;

  typedef enum logic [1:0] {
    L2_LOAD   = 2'd0,
    L2_STORE  = 2'd1,
    L2_FLUSH  = 2'd2,
    L2_MEMBAR = 2'd3
  } l2_op_t;

  typedef struct packed {
    logic        valid;
    l2_op_t      op;
    logic [31:0] address;
    logic [31:0] data;
  } l2req_packet_t;

  // A single requester still needs a 1-bit id/pointer.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/l2_request_arbiter_if.sv
// Core-side request/ready lanes plus the arbitrated L2 request port.
interface l2_request_arbiter_if
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = `NUM_CORES
);
  localparam int ID_W = id_width(NUM_REQUESTERS);

  l2req_packet_t [NUM_REQUESTERS-1:0] l2i_request;
  logic          [NUM_REQUESTERS-1:0] l2_ready;
  l2req_packet_t                      l2a_request;
  logic                               l2a_stall;
  logic          [ID_W-1:0]           l2a_grant_id;

  modport master (
    output l2i_request, l2a_stall,
    input  l2_ready, l2a_request, l2a_grant_id
  );

  modport slave (
    input  l2i_request, l2a_stall,
    output l2_ready, l2a_request, l2a_grant_id
  );
endinterface

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or above the pointer, wrapping
// at NUM_REQUESTERS (not necessarily a power of two).
module rr_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);
  localparam int PTR_W = id_width(NUM_REQUESTERS);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic [PTR_W:0]   sum;
  logic             any;

  always_comb begin
    grant_oh = '0;
    win      = rr_ptr;
    idx      = '0;
    sum      = '0;
    any      = 1'b0;
    for (int off = 0; off < NUM_REQUESTERS; off++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQUESTERS))
        sum = sum - (PTR_W+1)'(NUM_REQUESTERS);
      idx = sum[PTR_W-1:0];
      if (!any && request[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    if (any) grant_oh[win] = 1'b1;
  end

  // Explicit wrap keeps the pointer below NUM_REQUESTERS; N=1 pins it at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (update_lru && any)
      rr_ptr <= (win == PTR_W'(NUM_REQUESTERS-1)) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/l2_request_arbiter.sv
// Merges per-core one-entry request buffers into one registered L2 request
// port, round-robin, holding the output while the L2 stalls.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = `NUM_CORES
) (
  input  logic                 clk,
  input  logic                 reset,
  l2_request_arbiter_if.slave  bus
);
  localparam int ID_W = id_width(NUM_REQUESTERS);

  logic          [NUM_REQUESTERS-1:0] full;
  logic          [NUM_REQUESTERS-1:0] capture;
  logic          [NUM_REQUESTERS-1:0] grant_oh;
  l2req_packet_t [NUM_REQUESTERS-1:0] req_buf;
  logic          [ID_W-1:0]           grant_id;
  logic                               slot_free;
  logic                               grant_en;
  logic                               out_valid;
  logic          [ID_W-1:0]           out_id;
  l2req_packet_t                      out_pkt;

  assign bus.l2_ready = ~full;
  assign slot_free    = !out_valid || !bus.l2a_stall;
  assign grant_en     = slot_free && (|full);

  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      capture[i] = bus.l2i_request[i].valid && !full[i];
  end

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .request    (full),
    .update_lru (grant_en),
    .grant_oh   (grant_oh)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (grant_oh[i]) grant_id = ID_W'(i);
  end

  // Capture needs empty and grant needs full, so the two never hit one lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      full <= '0;
    else
      full <= (full & ~(grant_en ? grant_oh : '0)) | capture;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (capture[i]) req_buf[i] <= bus.l2i_request[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_id    <= '0;
    end else if (slot_free) begin
      out_valid <= |full;
      if (|full) out_id <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_en) out_pkt <= req_buf[grant_id];
  end

  always_comb begin
    bus.l2a_request       = out_pkt;
    bus.l2a_request.valid = out_valid;
  end

  assign bus.l2a_grant_id = out_id;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: a 4-core instance and a 3-core one.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  l2_request_arbiter_if #(.NUM_REQUESTERS(4)) bus4 ();
  l2_request_arbiter_if #(.NUM_REQUESTERS(3)) bus3 ();

  l2_request_arbiter #(.NUM_REQUESTERS(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  l2_request_arbiter #(.NUM_REQUESTERS(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cores must never present a request while not ready.
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < 4; c++)
        if (bus4.l2i_request[c].valid && !bus4.l2_ready[c]) begin
          bad++;
          $display("FAIL protocol4 core %0d: valid while ready=0", c);
        end
      for (int c = 0; c < 3; c++)
        if (bus3.l2i_request[c].valid && !bus3.l2_ready[c]) begin
          bad++;
          $display("FAIL protocol3 core %0d: valid while ready=0", c);
        end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus4.l2i_request = '0;
    bus3.l2i_request = '0;
  endtask

  task automatic present4(input int core, input logic [31:0] addr);
    bus4.l2i_request[core].valid   = 1'b1;
    bus4.l2i_request[core].op      = L2_LOAD;
    bus4.l2i_request[core].address = addr;
    bus4.l2i_request[core].data    = 32'hd000_0000 | addr;
  endtask

  task automatic present3(input int core, input logic [31:0] addr);
    bus3.l2i_request[core].valid   = 1'b1;
    bus3.l2i_request[core].op      = L2_STORE;
    bus3.l2i_request[core].address = addr;
    bus3.l2i_request[core].data    = addr;
  endtask

  // Leaves the bench at cycle 0: just after an edge, reset released.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    bus4.l2a_stall = 1'b0;
    bus3.l2a_stall = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus4.l2a_request.valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", bus4.l2a_request.valid);
    end
    total++;
    if (bus4.l2_ready !== 4'hf) begin
      bad++; $display("FAIL reset_ready: got %h want f", bus4.l2_ready);
    end
    total++;
    if (bus4.l2a_grant_id !== 2'd0) begin
      bad++; $display("FAIL reset_id: got %0d want 0", bus4.l2a_grant_id);
    end
    total++;
    if (bus3.l2_ready !== 3'h7 || bus3.l2a_request.valid !== 1'b0) begin
      bad++; $display("FAIL reset_n3: ready %h valid %b want 7 0", bus3.l2_ready, bus3.l2a_request.valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    present4(2, 32'h1000);
    step();
    clear_inputs();
    total++;
    if (bus4.l2_ready[2] !== 1'b0 || bus4.l2a_request.valid !== 1'b0) begin
      bad++; $display("FAIL single_c1: ready2 %b valid %b want 0 0", bus4.l2_ready[2], bus4.l2a_request.valid);
    end
    step();
    total++;
    if (bus4.l2a_request.valid !== 1'b1 || bus4.l2a_request.address !== 32'h1000) begin
      bad++; $display("FAIL single_out: valid %b addr %h want 1 1000", bus4.l2a_request.valid, bus4.l2a_request.address);
    end
    total++;
    if (bus4.l2a_grant_id !== 2'd2 || bus4.l2_ready[2] !== 1'b1) begin
      bad++; $display("FAIL single_id: id %0d ready2 %b want 2 1", bus4.l2a_grant_id, bus4.l2_ready[2]);
    end
    step();
    total++;
    if (bus4.l2a_request.valid !== 1'b0) begin
      bad++; $display("FAIL single_drain: valid %b want 0", bus4.l2a_request.valid);
    end
  endtask

  task automatic test_all_same();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      for (int c = 0; c < 4; c++) present4(c, 32'h2000 + 32'(round * 256 + c * 16));
      step();
      clear_inputs();
      total++;
      if (bus4.l2a_request.valid !== 1'b0 || bus4.l2_ready !== 4'h0) begin
        bad++; $display("FAIL all_capture r%0d: valid %b ready %h want 0 0", round, bus4.l2a_request.valid, bus4.l2_ready);
      end
      for (int k = 0; k < 4; k++) begin
        step();
        total++;
        if (bus4.l2a_request.valid !== 1'b1 || bus4.l2a_grant_id !== 2'(k) ||
            bus4.l2a_request.address !== 32'h2000 + 32'(round * 256 + k * 16)) begin
          bad++; $display("FAIL all_order r%0d k%0d: valid %b id %0d addr %h want 1 %0d %h", round, k,
                          bus4.l2a_request.valid, bus4.l2a_grant_id, bus4.l2a_request.address,
                          k, 32'h2000 + 32'(round * 256 + k * 16));
        end
      end
      total++;
      if (bus4.l2_ready !== 4'hf) begin
        bad++; $display("FAIL all_ready r%0d: got %h want f", round, bus4.l2_ready);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    present4(1, 32'h4100);
    present4(3, 32'h4300);
    step();
    clear_inputs();
    step();
    total++;
    if (bus4.l2a_request.valid !== 1'b1 || bus4.l2a_grant_id !== 2'd1) begin
      bad++; $display("FAIL stall_first: valid %b id %0d want 1 1", bus4.l2a_request.valid, bus4.l2a_grant_id);
    end
    bus4.l2a_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (bus4.l2a_request.valid !== 1'b1 || bus4.l2a_grant_id !== 2'd1 ||
          bus4.l2a_request.address !== 32'h4100 || bus4.l2_ready !== 4'b0111) begin
        bad++; $display("FAIL stall_hold k%0d: valid %b id %0d addr %h ready %h want 1 1 4100 7", k,
                        bus4.l2a_request.valid, bus4.l2a_grant_id, bus4.l2a_request.address, bus4.l2_ready);
      end
    end
    bus4.l2a_stall = 1'b0;
    step();
    total++;
    if (bus4.l2a_request.valid !== 1'b1 || bus4.l2a_grant_id !== 2'd3 || bus4.l2a_request.address !== 32'h4300) begin
      bad++; $display("FAIL stall_release: valid %b id %0d addr %h want 1 3 4300",
                      bus4.l2a_request.valid, bus4.l2a_grant_id, bus4.l2a_request.address);
    end
    step();
    total++;
    if (bus4.l2a_request.valid !== 1'b0) begin
      bad++; $display("FAIL stall_drain: valid %b want 0", bus4.l2a_request.valid);
    end
  endtask

  task automatic test_starvation();
    int grants[$];
    do_reset();
    present4(0, 32'h5000);
    present4(3, 32'h5300);
    for (int cyc = 0; cyc < 10 && grants.size() < 3; cyc++) begin
      step();
      clear_inputs();
      if (bus4.l2a_request.valid) grants.push_back(int'(bus4.l2a_grant_id));
      if (bus4.l2_ready[0]) present4(0, 32'h5000 + 32'(cyc));
    end
    clear_inputs();
    total++;
    if (grants.size() < 3) begin
      bad++; $display("FAIL starve_timeout: got %0d grants want 3", grants.size());
    end else begin
      total++;
      if (grants[0] !== 0 || grants[1] !== 3 || grants[2] !== 0) begin
        bad++; $display("FAIL starve_order: got %0d %0d %0d want 0 3 0", grants[0], grants[1], grants[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) present4(c, 32'h6000 + 32'(c));
    step();
    clear_inputs();
    bus4.l2a_stall = 1'b1;
    step();
    step();
    total++;
    if (bus4.l2a_request.valid !== 1'b1 || bus4.l2a_grant_id !== 2'd0 || bus4.l2_ready !== 4'b0001) begin
      bad++; $display("FAIL midrst_pre: valid %b id %0d ready %h want 1 0 1",
                      bus4.l2a_request.valid, bus4.l2a_grant_id, bus4.l2_ready);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (bus4.l2a_request.valid !== 1'b0 || bus4.l2_ready !== 4'hf || bus4.l2a_grant_id !== 2'd0) begin
      bad++; $display("FAIL midrst_async: valid %b ready %h id %0d want 0 f 0",
                      bus4.l2a_request.valid, bus4.l2_ready, bus4.l2a_grant_id);
    end
    bus4.l2a_stall = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_npot();
    int grants[$];
    do_reset();
    for (int c = 0; c < 3; c++) present3(c, 32'h7000 + 32'(c));
    for (int cyc = 0; cyc < 20 && grants.size() < 9; cyc++) begin
      step();
      clear_inputs();
      if (bus3.l2a_request.valid) grants.push_back(int'(bus3.l2a_grant_id));
      for (int c = 0; c < 3; c++)
        if (bus3.l2_ready[c]) present3(c, 32'h7000 + 32'(c));
    end
    clear_inputs();
    total++;
    if (grants.size() < 9) begin
      bad++; $display("FAIL npot_timeout: got %0d grants want 9", grants.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        total++;
        if (grants[k] !== k % 3) begin
          bad++; $display("FAIL npot_order k%0d: got %0d want %0d", k, grants[k], k % 3);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    bus4.l2a_stall = 1'b0;
    bus3.l2a_stall = 1'b0;
    test_reset();
    test_single();
    test_all_same();
    test_stall();
    test_starvation();
    test_reset_mid();
    test_npot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
